// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port, with launches paced by the pixel strobe during active lines.
// Optional macro SPRITE_ARB_HBLANK_GUARD_EN blocks active-line launches at H_pos_in >= 636.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pixel_clk,
  input  logic                      line_active,
  input  logic [9:0]                H_pos_in,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ID_W-1:0]           rd_id,
  output logic [7:0]                grants_this_line
);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   last_win;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [ADDR_W-1:0] pick_addr;
  logic              line_q;
  logic              line_rise;
  logic              h_ok;
  logic              launch_ok;

`ifdef SPRITE_ARB_HBLANK_GUARD_EN
  // Last usable launch position keeps the 4-cycle fetch inside the active line.
  assign h_ok = (H_pos_in < 10'd636);
`else
  logic unused_hpos;
  assign unused_hpos = ^H_pos_in;
  assign h_ok = 1'b1;
`endif

  assign launch_ok = !line_active || (pixel_clk && h_ok);
  assign line_rise = line_active && !line_q;
  assign pick_addr = req_addr[pick*ADDR_W +: ADDR_W];

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_win) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ARB;
      last_win         <= ID_W'(NUM_REQ - 1);
      line_q           <= 1'b0;
      gnt              <= '0;
      rom_en           <= 1'b0;
      rom_addr         <= '0;
      rd_valid         <= 1'b0;
      rd_data          <= '0;
      rd_id            <= '0;
      grants_this_line <= '0;
    end else begin
      line_q   <= line_active;
      gnt      <= '0;
      rom_en   <= 1'b0;
      rd_valid <= 1'b0;

      if (line_rise)
        grants_this_line <= (state == ISSUE) ? 8'd1 : 8'd0;
      else if (state == ISSUE && grants_this_line != 8'hFF)
        grants_this_line <= grants_this_line + 8'd1;

      case (state)
        ARB: begin
          if (launch_ok && found) begin
            last_win <= pick;
            gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            rom_en   <= 1'b1;
            rom_addr <= pick_addr;
            state    <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rd_data  <= rom_data;
          rd_id    <= last_win;
          rd_valid <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

endmodule
